// File: rtl/vending_pkg.sv
// rtl/vending_pkg.sv - shared types and coin constants for the coin scheduler
package vending_pkg;

    typedef enum logic [1:0] {
        NICKLE  = 2'd0,
        DIME    = 2'd1,
        QUARTER = 2'd2
    } coin_e;

    localparam logic [2:0] NICKLE_VALUE  = 3'd1;
    localparam logic [2:0] DIME_VALUE    = 3'd2;
    localparam logic [2:0] QUARTER_VALUE = 3'd5;

    localparam int PRICE_DEFAULT = 4;

    typedef enum logic [2:0] {
        S_IDLE,
        S_ISSUE,
        S_GAP,
        S_WAIT_SODA,
        S_HOLDOFF
    } sched_state_e;

    // Value in nickels of a one-hot coin vector indexed by coin_e.
    function automatic logic [2:0] coin_value(input logic [2:0] onehot);
        coin_value = 3'd0;
        if (onehot[NICKLE])  coin_value = NICKLE_VALUE;
        if (onehot[DIME])    coin_value = DIME_VALUE;
        if (onehot[QUARTER]) coin_value = QUARTER_VALUE;
    endfunction

endpackage

// File: rtl/rr_arbiter3.sv
// rtl/rr_arbiter3.sv - three-way round-robin arbiter, pointer marks highest priority
module rr_arbiter3
    import vending_pkg::*;
(
    input  logic       i_clk,
    input  logic       i_rst_n,
    input  logic [2:0] i_req,
    input  logic       i_advance,
    output logic [2:0] o_grant,
    output logic [1:0] o_ptr
);

    logic [1:0] ptr;
    logic [1:0] ptr_d;
    logic [1:0] c0;
    logic [1:0] c1;
    logic [1:0] c2;

    function automatic logic [1:0] next_idx(input logic [1:0] idx);
        next_idx = (idx == QUARTER) ? NICKLE : idx + 2'd1;
    endfunction

    always_comb begin
        c0      = ptr;
        c1      = next_idx(c0);
        c2      = next_idx(c1);
        o_grant = 3'b000;
        ptr_d   = ptr;
        // The winner's successor becomes the new highest priority.
        if (i_req[c0]) begin
            o_grant[c0] = 1'b1;
            ptr_d       = c1;
        end else if (i_req[c1]) begin
            o_grant[c1] = 1'b1;
            ptr_d       = c2;
        end else if (i_req[c2]) begin
            o_grant[c2] = 1'b1;
            ptr_d       = c0;
        end
    end

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            ptr <= NICKLE;
        end else if (i_advance) begin
            ptr <= ptr_d;
        end
    end

    assign o_ptr = ptr;

endmodule

// File: rtl/coin_scheduler.sv
// rtl/coin_scheduler.sv - paces detected coins into the vending machine one at a time
module coin_scheduler
    import vending_pkg::*;
#(
    parameter int MAX_PEND = 3,
    parameter int GAP      = 2,
    parameter int HOLD     = 2,
    parameter int PRICE    = PRICE_DEFAULT
) (
    input  logic       i_clk,
    input  logic       i_rst_n,
    input  logic       i_nickle_det,
    input  logic       i_dime_det,
    input  logic       i_quarter_det,
    input  logic       i_soda,
    output logic       o_nickle,
    output logic       o_dime,
    output logic       o_quarter,
    output logic       o_reject,
    output logic       o_busy,
    output logic [2:0] o_credit
);

    localparam int CW   = $clog2(MAX_PEND + 1);
    localparam int TMAX = (GAP > HOLD) ? GAP : HOLD;
    localparam int TW   = (TMAX < 2) ? 1 : $clog2(TMAX + 1);
    localparam logic [CW-1:0] PEND_ONE  = CW'(1);
    localparam logic [CW-1:0] PEND_FULL = CW'(MAX_PEND);

    logic [2:0]    det;
    logic [2:0]    det_q;
    logic [2:0]    ev;
    logic [CW-1:0] pend [3];
    logic [2:0]    req;
    logic [2:0]    grant;
    logic [2:0]    take;
    logic [2:0]    drop;
    logic [1:0]    rr_ptr_unused;
    logic          issue;
    logic [2:0]    coin_q;
    logic          reject_q;
    logic [2:0]    credit;
    logic [2:0]    credit_d;
    logic [3:0]    credit_sum;
    logic [TW-1:0] timer;
    logic [TW-1:0] timer_d;
    sched_state_e  state;
    sched_state_e  state_d;

    assign det  = {i_quarter_det, i_dime_det, i_nickle_det};
    assign ev   = det & ~det_q;
    assign take = grant & {3{issue}};

    always_comb begin
        req  = 3'b000;
        drop = 3'b000;
        for (int i = 0; i < 3; i++) begin
            req[i]  = (pend[i] != '0);
            drop[i] = ev[i] & ~take[i] & (pend[i] == PEND_FULL);
        end
    end

    rr_arbiter3 u_arb (
        .i_clk     (i_clk),
        .i_rst_n   (i_rst_n),
        .i_req     (req),
        .i_advance (issue),
        .o_grant   (grant),
        .o_ptr     (rr_ptr_unused)
    );

    assign credit_sum = {1'b0, credit} + {1'b0, coin_value(grant)};

    always_comb begin
        state_d  = state;
        timer_d  = timer;
        credit_d = credit;
        issue    = 1'b0;
        // A soda outside WAIT_SODA means we lost sync with the machine; same recovery.
        if (i_soda) begin
            credit_d = 3'd0;
            timer_d  = TW'(HOLD);
            state_d  = S_HOLDOFF;
        end else begin
            case (state)
                S_IDLE: begin
                    if ((req != 3'b000) && (credit < 3'(PRICE))) begin
                        issue    = 1'b1;
                        credit_d = credit_sum[3] ? 3'd7 : credit_sum[2:0];
                        state_d  = S_ISSUE;
                    end
                end
                S_ISSUE: begin
                    if (credit >= 3'(PRICE)) begin
                        state_d = S_WAIT_SODA;
                    end else begin
                        timer_d = TW'(GAP);
                        state_d = S_GAP;
                    end
                end
                S_GAP, S_HOLDOFF: begin
                    if (timer != '0) timer_d = timer - TW'(1);
                    if (timer <= TW'(1)) state_d = S_IDLE;
                end
                S_WAIT_SODA: state_d = S_WAIT_SODA;
                default:     state_d = S_IDLE;
            endcase
        end
    end

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            state    <= S_IDLE;
            timer    <= '0;
            credit   <= 3'd0;
            coin_q   <= 3'b000;
            reject_q <= 1'b0;
            det_q    <= 3'b000;
            for (int i = 0; i < 3; i++) pend[i] <= '0;
        end else begin
            state    <= state_d;
            timer    <= timer_d;
            credit   <= credit_d;
            coin_q   <= take;
            reject_q <= |drop;
            det_q    <= det;
            for (int i = 0; i < 3; i++) begin
                if (ev[i] && !take[i] && (pend[i] != PEND_FULL)) begin
                    pend[i] <= pend[i] + PEND_ONE;
                end else if (!ev[i] && take[i]) begin
                    pend[i] <= pend[i] - PEND_ONE;
                end
            end
        end
    end

    assign o_nickle  = coin_q[NICKLE];
    assign o_dime    = coin_q[DIME];
    assign o_quarter = coin_q[QUARTER];
    assign o_reject  = reject_q;
    assign o_credit  = credit;
    assign o_busy    = (state != S_IDLE) || (req != 3'b000);

endmodule

// File: tb/tb_coin_scheduler.sv
// tb/tb_coin_scheduler.sv - directed self-checking bench for coin_scheduler
module tb_coin_scheduler;

    logic       i_clk;
    logic       i_rst_n;
    logic       i_nickle_det;
    logic       i_dime_det;
    logic       i_quarter_det;
    logic       i_soda;
    logic       o_nickle;
    logic       o_dime;
    logic       o_quarter;
    logic       o_reject;
    logic       o_busy;
    logic [2:0] o_credit;

    int n_cmp;
    int n_bad;

    coin_scheduler dut (
        .i_clk         (i_clk),
        .i_rst_n       (i_rst_n),
        .i_nickle_det  (i_nickle_det),
        .i_dime_det    (i_dime_det),
        .i_quarter_det (i_quarter_det),
        .i_soda        (i_soda),
        .o_nickle      (o_nickle),
        .o_dime        (o_dime),
        .o_quarter     (o_quarter),
        .o_reject      (o_reject),
        .o_busy        (o_busy),
        .o_credit      (o_credit)
    );

    initial i_clk = 1'b0;
    always #5 i_clk = ~i_clk;

    task automatic apply_reset();
        i_nickle_det  = 1'b0;
        i_dime_det    = 1'b0;
        i_quarter_det = 1'b0;
        i_soda        = 1'b0;
        i_rst_n       = 1'b0;
        @(negedge i_clk);
        @(negedge i_clk);
        i_rst_n = 1'b1;
    endtask

    task automatic test_reset();
        apply_reset();
        n_cmp++;
        if ({o_nickle, o_dime, o_quarter, o_reject, o_busy, o_credit} !== 8'h00) begin
            n_bad++;
            $display("FAIL reset_outputs: got %b expected 00000000",
                     {o_nickle, o_dime, o_quarter, o_reject, o_busy, o_credit});
        end
    endtask

    task automatic test_single_dime();
        int pulses;
        int at;
        pulses = 0;
        at     = -1;
        apply_reset();
        i_dime_det = 1'b1;
        @(negedge i_clk);
        n_cmp++;
        if (o_dime !== 1'b0 || o_busy !== 1'b1) begin
            n_bad++;
            $display("FAIL dime_s1: dime=%b busy=%b expected dime=0 busy=1", o_dime, o_busy);
        end
        i_dime_det = 1'b0;
        for (int k = 2; k <= 8; k++) begin
            @(negedge i_clk);
            if (o_dime === 1'b1) begin
                pulses++;
                at = k;
            end
            if (k == 2) begin
                n_cmp++;
                if (o_credit !== 3'd2) begin
                    n_bad++;
                    $display("FAIL dime_credit: got %0d expected 2", o_credit);
                end
            end
            if (k == 4) begin
                n_cmp++;
                if (o_busy !== 1'b1) begin
                    n_bad++;
                    $display("FAIL dime_busy_gap: got %b expected 1", o_busy);
                end
            end
            if (k == 5) begin
                n_cmp++;
                if (o_busy !== 1'b0) begin
                    n_bad++;
                    $display("FAIL dime_busy_idle: got %b expected 0", o_busy);
                end
            end
        end
        n_cmp++;
        if (pulses != 1 || at != 2) begin
            n_bad++;
            $display("FAIL dime_pulse: count=%0d at=%0d expected count=1 at=2", pulses, at);
        end
    endtask

    task automatic test_simultaneous();
        int n_at, d_at, q_at, total, multi;
        n_at = -1; d_at = -1; q_at = -1; total = 0; multi = 0;
        apply_reset();
        i_nickle_det  = 1'b1;
        i_dime_det    = 1'b1;
        i_quarter_det = 1'b1;
        @(negedge i_clk);
        i_nickle_det  = 1'b0;
        i_dime_det    = 1'b0;
        i_quarter_det = 1'b0;
        for (int k = 2; k <= 18; k++) begin
            @(negedge i_clk);
            if (o_nickle === 1'b1 && n_at < 0) n_at = k;
            if (o_dime === 1'b1 && d_at < 0) d_at = k;
            if (o_quarter === 1'b1 && q_at < 0) q_at = k;
            total += int'(o_nickle) + int'(o_dime) + int'(o_quarter);
            if (int'(o_nickle) + int'(o_dime) + int'(o_quarter) > 1) multi++;
        end
        n_cmp++;
        if (n_at != 2 || d_at != 6 || q_at != 10) begin
            n_bad++;
            $display("FAIL rr_order: nickel@%0d dime@%0d quarter@%0d expected 2 6 10", n_at, d_at, q_at);
        end
        n_cmp++;
        if (total != 3 || multi != 0) begin
            n_bad++;
            $display("FAIL rr_count: pulses=%0d multi=%0d expected 3 0", total, multi);
        end
        n_cmp++;
        if (o_credit !== 3'd7 || o_busy !== 1'b1) begin
            n_bad++;
            $display("FAIL rr_saturate: credit=%0d busy=%b expected 7 1", o_credit, o_busy);
        end
    endtask

    task automatic test_reject();
        int dimes;
        apply_reset();
        i_quarter_det = 1'b1;
        @(negedge i_clk);
        i_quarter_det = 1'b0;
        @(negedge i_clk);
        @(negedge i_clk);
        n_cmp++;
        if (o_credit !== 3'd5) begin
            n_bad++;
            $display("FAIL rej_credit: got %0d expected 5", o_credit);
        end
        for (int j = 0; j < 4; j++) begin
            i_dime_det = 1'b1;
            @(negedge i_clk);
            n_cmp++;
            if (o_reject !== (j == 3) || o_dime !== 1'b0) begin
                n_bad++;
                $display("FAIL rej_edge%0d: reject=%b dime=%b expected reject=%b dime=0",
                         j, o_reject, o_dime, (j == 3));
            end
            i_dime_det = 1'b0;
            @(negedge i_clk);
            n_cmp++;
            if (o_reject !== 1'b0) begin
                n_bad++;
                $display("FAIL rej_clear%0d: got %b expected 0", j, o_reject);
            end
        end
        dimes    = 0;
        i_soda   = 1'b1;
        @(negedge i_clk);
        i_soda   = 1'b0;
        for (int k = 1; k <= 12; k++) begin
            @(negedge i_clk);
            if (o_dime === 1'b1) dimes++;
        end
        n_cmp++;
        if (dimes != 2 || o_credit !== 3'd4) begin
            n_bad++;
            $display("FAIL rej_drain1: dimes=%0d credit=%0d expected 2 4", dimes, o_credit);
        end
        dimes  = 0;
        i_soda = 1'b1;
        @(negedge i_clk);
        i_soda = 1'b0;
        for (int k = 1; k <= 8; k++) begin
            @(negedge i_clk);
            if (o_dime === 1'b1) dimes++;
        end
        n_cmp++;
        if (dimes != 1 || o_credit !== 3'd2 || o_busy !== 1'b0) begin
            n_bad++;
            $display("FAIL rej_drain2: dimes=%0d credit=%0d busy=%b expected 1 2 0",
                     dimes, o_credit, o_busy);
        end
    endtask

    task automatic test_soda_holdoff();
        int early;
        early = 0;
        apply_reset();
        i_quarter_det = 1'b1;
        @(negedge i_clk);
        i_quarter_det = 1'b0;
        @(negedge i_clk);
        n_cmp++;
        if (o_quarter !== 1'b1 || o_credit !== 3'd5) begin
            n_bad++;
            $display("FAIL soda_first: quarter=%b credit=%0d expected 1 5", o_quarter, o_credit);
        end
        i_quarter_det = 1'b1;
        @(negedge i_clk);
        i_quarter_det = 1'b0;
        for (int k = 0; k < 4; k++) begin
            @(negedge i_clk);
            if (o_quarter === 1'b1) early++;
        end
        n_cmp++;
        if (early != 0 || o_credit !== 3'd5) begin
            n_bad++;
            $display("FAIL soda_wait: pulses=%0d credit=%0d expected 0 5", early, o_credit);
        end
        i_soda = 1'b1;
        @(negedge i_clk);
        i_soda = 1'b0;
        n_cmp++;
        if (o_credit !== 3'd0 || o_quarter !== 1'b0) begin
            n_bad++;
            $display("FAIL soda_clear: credit=%0d quarter=%b expected 0 0", o_credit, o_quarter);
        end
        for (int k = 1; k <= 2; k++) begin
            @(negedge i_clk);
            n_cmp++;
            if (o_quarter !== 1'b0) begin
                n_bad++;
                $display("FAIL soda_hold%0d: got %b expected 0", k, o_quarter);
            end
        end
        @(negedge i_clk);
        n_cmp++;
        if (o_quarter !== 1'b1 || o_credit !== 3'd5) begin
            n_bad++;
            $display("FAIL soda_second: quarter=%b credit=%0d expected 1 5", o_quarter, o_credit);
        end
    endtask

    task automatic test_held_sensor();
        int pulses;
        pulses = 0;
        apply_reset();
        i_dime_det = 1'b1;
        for (int k = 1; k <= 16; k++) begin
            @(negedge i_clk);
            if (k == 10) i_dime_det = 1'b0;
            if (o_dime === 1'b1) pulses++;
        end
        n_cmp++;
        if (pulses != 1 || o_credit !== 3'd2 || o_busy !== 1'b0) begin
            n_bad++;
            $display("FAIL held_dime: pulses=%0d credit=%0d busy=%b expected 1 2 0",
                     pulses, o_credit, o_busy);
        end
    endtask

    task automatic test_reset_mid_gap();
        int pulses;
        pulses = 0;
        apply_reset();
        for (int k = 1; k <= 7; k++) begin
            i_nickle_det = (k % 2 == 1);
            @(negedge i_clk);
            if (o_nickle === 1'b1) pulses++;
        end
        n_cmp++;
        if (pulses != 2 || o_credit !== 3'd2 || o_busy !== 1'b1) begin
            n_bad++;
            $display("FAIL mid_setup: pulses=%0d credit=%0d busy=%b expected 2 2 1",
                     pulses, o_credit, o_busy);
        end
        i_nickle_det = 1'b0;
        i_rst_n      = 1'b0;
        #1;
        n_cmp++;
        if ({o_nickle, o_dime, o_quarter, o_reject, o_busy, o_credit} !== 8'h00) begin
            n_bad++;
            $display("FAIL mid_reset: got %b expected 00000000",
                     {o_nickle, o_dime, o_quarter, o_reject, o_busy, o_credit});
        end
        @(negedge i_clk);
        @(negedge i_clk);
        i_rst_n = 1'b1;
        pulses  = 0;
        for (int k = 1; k <= 10; k++) begin
            @(negedge i_clk);
            pulses += int'(o_nickle) + int'(o_dime) + int'(o_quarter) + int'(o_reject);
        end
        n_cmp++;
        if (pulses != 0 || o_busy !== 1'b0) begin
            n_bad++;
            $display("FAIL mid_after: pulses=%0d busy=%b expected 0 0", pulses, o_busy);
        end
    endtask

    initial begin
        n_cmp = 0;
        n_bad = 0;
        test_reset();
        test_single_dime();
        test_simultaneous();
        test_reject();
        test_soda_holdoff();
        test_held_sensor();
        test_reset_mid_gap();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule

// File: doc/coin_scheduler.md
Name: coin_scheduler

Overview:
Sits between the raw coin-slot sensors and the vending_machine FSM. It edge-detects the three sensors, counts pending coins per denomination, and picks one coin at a time with a round-robin arbiter. Each coin goes to the vending machine as a single-cycle one-hot pulse, timed so that it always lands while the machine is in its coin-accept state. The block also tracks credit, so it stops feeding coins once the price is reached and waits for the soda before issuing again.

Parameters:
MAX_PEND, 3, maximum pending coins held per denomination (counter width = clog2(MAX_PEND+1)).
GAP, 2, minimum idle cycles after an issued coin before the next issue (covers the add->s1 return).
HOLD, 2, idle cycles after o_soda is observed before issue resumes (covers disp->s0->s1).
PRICE, 4, credit threshold in nickel units (20 cents).

Ports:
i_clk  input  1  system clock, rising edge.
i_rst_n  input  1  asynchronous active-low reset.
i_nickle_det  input  1  nickel sensor level; one coin per rising edge.
i_dime_det  input  1  dime sensor level; one coin per rising edge.
i_quarter_det  input  1  quarter sensor level; one coin per rising edge.
i_soda  input  1  o_soda from vending_machine; vend-complete indication.
o_nickle  output  1  one-cycle nickel pulse to vending_machine.
o_dime  output  1  one-cycle dime pulse to vending_machine.
o_quarter  output  1  one-cycle quarter pulse to vending_machine.
o_reject  output  1  one-cycle pulse: a detected coin was dropped because its counter was full.
o_busy  output  1  high when any counter is nonzero or the FSM is not IDLE.
o_credit  output  3  credit issued since the last soda, in nickel units.

Behaviour:
- Reset (async, i_rst_n=0):
  - all outputs 0; FSM in IDLE; counters, credit and the RR pointer (nickel) cleared.
  - edge-detect registers cleared, so a sensor that is high when reset releases counts as one edge on the first clock.
- Edge detect: coin event = det & ~det_q, registered each cycle. Sensor input is synchronous; no synchronizer in this block.
- Pending counters, one per denomination:
  - increment on event; decrement on grant of that denomination.
  - event and grant in the same cycle: count unchanged.
  - event while count==MAX_PEND with no grant that cycle: coin dropped, o_reject=1 next cycle.
  - events on several denominations in one cycle are all accepted.
- Arbiter:
  - requests are counters > 0; grant is one-hot in order nickel->dime->quarter, starting after the last granted denomination.
  - pointer advances only on an actual issue.
- Coin values (nickels): nickel 1, dime 2, quarter 5. Credit is 3 bits, saturating at 7, and clears on i_soda.
- FSM:
  - IDLE: if any request and credit<PRICE: register the grant onto o_* (registered, 1 cycle), add its value to credit, go to ISSUE.
  - ISSUE: outputs deassert. If new credit>=PRICE go to WAIT_SODA, else go to GAP with gap counter=GAP.
  - GAP: decrement counter; at 0 go to IDLE.
  - WAIT_SODA: no issue; on i_soda clear credit, load HOLD, go to HOLDOFF.
  - HOLDOFF: decrement; at 0 go to IDLE.
  - i_soda in any state other than WAIT_SODA: clear credit, go to HOLDOFF (resync).
- Latency: sensor edge in cycle n gives coin pulse at cycle n+2 at earliest (counter update, then IDLE grant register).
- At most one of o_nickle/o_dime/o_quarter is high in any cycle. Pulses are exactly 1 cycle and separated by at least GAP+1 cycles.
- Reset mid-operation: pending coins lost silently; no o_reject.

Decomposition:
- vending_pkg:
  - coin_e enum (NICKLE, DIME, QUARTER);
  - coin value constants (1, 2, 5);
  - PRICE default;
  - sched_state_e (IDLE, ISSUE, GAP, WAIT_SODA, HOLDOFF).
- One sub-module: rr_arbiter3. Inputs: 3-bit request, advance strobe. Outputs: one-hot grant, internal pointer.

Test Plan:
- Single dime edge with credit 0 -> o_dime high exactly 1 cycle, 2 cycles after the edge; o_credit=2; FSM passes through GAP; o_busy drops after GAP.
- Nickel, dime and quarter rising in the same cycle -> issued in order nickel, dime, quarter, each >=3 cycles apart. After the quarter o_credit=8 saturates to 7 -> WAIT_SODA with no further pulses.
- Four dime edges with MAX_PEND=3 and no grant possible (WAIT_SODA) -> counter stays at 3, one o_reject pulse, no pulse on o_dime.
- Two quarters pending; first issued, credit 5 -> WAIT_SODA. Pulse i_soda -> credit 0, HOLD=2 idle cycles, then second quarter issued.
- Dime sensor held high for 10 cycles -> exactly one dime counted and issued.
- Assert i_rst_n=0 while in GAP with 2 nickels pending -> all outputs 0 immediately, counters 0. After release with sensors low, no pulses are issued.
